// File: rtl/fp_st_pkg.sv
// Shared constants and types for the store-side native-extended to x87 converter.
// No logic; consumed by st_native_ext_to_x87 and st_ext_denorm_round.
// Exponent fields are 16-bit native (bias 7FFF) and 15-bit x87 (bias 3FFF).
package fp_st_pkg;

    localparam logic [15:0] NAT_EXT_BIAS = 16'h7FFF;
    localparam logic [14:0] X87_BIAS     = 15'h3FFF;
    localparam logic [15:0] NAT_EXT_INF  = 16'hFFFF;
    localparam logic [15:0] DEN_LIMIT    = 16'h4000;
    // Smallest native exponent whose x87 rebias no longer fits below all-ones.
    localparam logic [15:0] OVF_LIMIT    = 16'hBFFF;
    // Difference of the two biases; subtracting it re-biases the exponent.
    localparam logic [15:0] REBIAS       = NAT_EXT_BIAS - {1'b0, X87_BIAS};
    // Shifting by this much or more pushes every mantissa bit past guard.
    localparam logic [6:0]  SH_MAX       = 7'd65;

    typedef enum logic [2:0] {ZERO, SPECIAL, OVF, DEN, NORM} ext_cls_e;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} out_state_e;

    // Classified operand held in S1.
    typedef struct packed {
        logic        sign;
        ext_cls_e    cls;
        logic [14:0] x;
        logic [6:0]  sh;
        logic [63:0] mant;
    } s1_op_t;

    // Packed x87 result held in S2 while its two beats drain.
    typedef struct packed {
        logic        sign;
        logic [14:0] x;
        logic [63:0] mant;
    } s2_op_t;

endpackage

// File: rtl/st_ext_denorm_round.sv
// Right-shifts a mantissa into x87 denormal range with round-to-nearest-even.
// Latency: combinational, zero cycles.
// Backpressure: none; purely a function of its inputs.
module st_ext_denorm_round
    import fp_st_pkg::*;
(
    input  logic [63:0] mant,
    input  logic [6:0]  sh,
    output logic [63:0] res,
    output logic        carry
);

    logic [127:0] wide;
    logic [63:0]  kept;
    logic         guard;
    logic         sticky;
    logic         rnd_up;

    // Shift through a double-width window so guard and sticky fall out of the low half.
    always_comb begin
        wide   = {mant, 64'd0} >> sh;
        kept   = wide[127:64];
        guard  = wide[63];
        sticky = |wide[62:0];
        rnd_up = guard & (sticky | kept[0]);
        if (sh >= SH_MAX) begin
            res = '0;
        end else begin
            res = kept + {63'd0, rnd_up};
        end
        // Shift is at least one here, so bit 63 can only come from the rounding carry.
        carry = res[63];
    end

endmodule

// File: rtl/st_native_ext_to_x87.sv
// Converts an 81-bit native extended operand into two 64-bit x87 store-data beats.
// Latency: accept at edge t -> beat0 valid after t+1, beat1 after the next out_ready edge.
// Backpressure: out_ready low holds the current beat; S1 then fills and in_ready drops.
module st_native_ext_to_x87
    import fp_st_pkg::*;
#(
    parameter int TAG_W = 8
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [80:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_last,
    output logic [TAG_W-1:0] out_tag
);

    logic [15:0]      in_exp;
    logic [63:0]      in_mant;
    logic [16:0]      sh_full;
    s1_op_t           s1_nxt;
    s1_op_t           s1_q;
    logic             s1_valid;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_advance;
    out_state_e       state;
    out_state_e       state_nxt;
    s2_op_t           s2_nxt;
    s2_op_t           s2_q;
    logic [TAG_W-1:0] s2_tag;
    logic [63:0]      den_mant;
    logic             den_carry;

    // S1 empties into S2 when S2 is empty or is handing off its last beat.
    assign s1_advance = s1_valid & ((state == IDLE) | ((state == BEAT1) & out_ready));
    assign in_ready   = ~s1_valid | s1_advance;

    // Decode the scattered exponent and classify the incoming operand.
    always_comb begin
        in_exp      = {in_data[79], in_data[64], in_data[78:65]};
        in_mant     = in_data[63:0];
        sh_full     = {1'b0, DEN_LIMIT} + 17'd1 - {1'b0, in_exp};
        s1_nxt      = '0;
        s1_nxt.sign = in_data[80];
        s1_nxt.mant = in_mant;
        s1_nxt.x    = in_exp[14:0] - REBIAS[14:0];
        s1_nxt.sh   = (sh_full > {10'd0, SH_MAX}) ? SH_MAX : sh_full[6:0];
        if (in_exp == 16'd0 || in_mant == 64'd0) begin
            s1_nxt.cls = ZERO;
        end else if (in_exp == NAT_EXT_INF) begin
            s1_nxt.cls = SPECIAL;
        end else if (in_exp >= OVF_LIMIT) begin
            s1_nxt.cls = OVF;
        end else if (in_exp <= DEN_LIMIT) begin
            s1_nxt.cls = DEN;
        end else begin
            s1_nxt.cls = NORM;
        end
    end

    // S1 register: refills in the same cycle its content moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s1_tag   <= '0;
        end else if (in_valid & in_ready) begin
            s1_valid <= 1'b1;
            s1_q     <= s1_nxt;
            s1_tag   <= in_tag;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    st_ext_denorm_round u_denorm (
        .mant  (s1_q.mant),
        .sh    (s1_q.sh),
        .res   (den_mant),
        .carry (den_carry)
    );

    // Pack the x87 exponent and mantissa for each class.
    always_comb begin
        s2_nxt      = '0;
        s2_nxt.sign = s1_q.sign;
        case (s1_q.cls)
            ZERO: begin
                s2_nxt.x    = '0;
                s2_nxt.mant = '0;
            end
            SPECIAL: begin
                s2_nxt.x    = 15'h7FFF;
                s2_nxt.mant = s1_q.mant;
                // An all-zero payload would read back as infinity; keep it a quiet NaN.
                if (s1_q.mant[62:0] == 63'd0) begin
                    s2_nxt.mant[62] = 1'b1;
                end
            end
            OVF: begin
                s2_nxt.x    = 15'h7FFF;
                s2_nxt.mant = 64'h8000_0000_0000_0000;
            end
            DEN: begin
                s2_nxt.x    = {14'd0, den_carry};
                s2_nxt.mant = den_mant;
            end
            default: begin
                s2_nxt.x    = s1_q.x;
                s2_nxt.mant = s1_q.mant;
            end
        endcase
    end

    // Beat sequencing: mantissa beat, then sign/exponent beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (s1_advance) state_nxt = BEAT0;
            BEAT0:   if (out_ready) state_nxt = BEAT1;
            BEAT1:   if (out_ready) state_nxt = s1_advance ? BEAT0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // S2 register and output state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            s2_q   <= '0;
            s2_tag <= '0;
        end else begin
            state <= state_nxt;
            if (s1_advance) begin
                s2_q   <= s2_nxt;
                s2_tag <= s1_tag;
            end
        end
    end

    assign out_valid = (state != IDLE);
    assign out_last  = (state == BEAT1);
    assign out_tag   = s2_tag;

    // Select the beat payload from the held S2 result.
    always_comb begin
        case (state)
            BEAT0:   out_data = s2_q.mant;
            BEAT1:   out_data = {48'd0, s2_q.sign, s2_q.x};
            default: out_data = '0;
        endcase
    end

endmodule

// File: tb/tb_st_native_ext_to_x87.sv
module tb_st_native_ext_to_x87;

    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [80:0]      in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic             out_last;
    logic [TAG_W-1:0] out_tag;

    typedef struct {
        logic [63:0] dat;
        logic        last;
        logic [7:0]  tag;
    } beat_t;

    beat_t sb[$];
    int    stream_cyc[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;

    st_native_ext_to_x87 #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output handshake is checked against the scoreboard head.
    always @(negedge clk) begin : mon
        beat_t e;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat data=%h last=%b tag=%h required=no beat", out_data, out_last, out_tag);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.dat || out_last !== e.last || out_tag !== e.tag) begin
                    bad++;
                    $display("FAIL beat actual data=%h last=%b tag=%h required data=%h last=%b tag=%h",
                             out_data, out_last, out_tag, e.dat, e.last, e.tag);
                end
            end
            if (out_tag >= 8'h20 && out_tag <= 8'h23) stream_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Queue the expected beat pair, then present the operand until accepted.
    task automatic send(input logic s, input logic [15:0] e, input logic [63:0] m,
                        input logic [7:0] tag, input logic [63:0] b0, input logic [15:0] b1);
        logic hs;
        int   n;
        sb.push_back('{b0, 1'b0, tag});
        sb.push_back('{{48'd0, b1}, 1'b1, tag});
        in_valid = 1'b1;
        in_data  = {s, e[15], e[13:0], e[14], m};
        in_tag   = tag;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) begin
            total++;
            bad++;
            $display("FAIL accept_timeout tag=%h in_ready=%b required=1", tag, in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", 64'(sb.size()), 64'd0);
    endtask

    initial begin : wdog
        #400000;
        total++;
        bad++;
        $display("FAIL watchdog expired");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : stim
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last",  out_last,  0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_out_tag",   out_tag,   0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed class coverage with out_ready held high.
        out_ready = 1'b1;
        send(0, 16'h7FFF, 64'h8000_0000_0000_0000, 8'h01, 64'h8000_0000_0000_0000, 16'h3FFF);
        send(1, 16'h8000, 64'h8000_0000_0000_0000, 8'h02, 64'h8000_0000_0000_0000, 16'hC000);
        send(0, 16'h4000, 64'hC000_0000_0000_0001, 8'h03, 64'h6000_0000_0000_0000, 16'h0000);
        send(0, 16'hC000, 64'hF234_5678_9ABC_DEF0, 8'h04, 64'h8000_0000_0000_0000, 16'h7FFF);
        send(0, 16'hFFFF, 64'h8000_0000_0000_0000, 8'h05, 64'hC000_0000_0000_0000, 16'h7FFF);
        send(1, 16'h0001, 64'hFFFF_FFFF_FFFF_FFFF, 8'h06, 64'h0000_0000_0000_0000, 16'h8000);
        send(0, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h07, 64'h8000_0000_0000_0000, 16'h0001);
        send(1, 16'h1234, 64'h0000_0000_0000_0000, 8'h08, 64'h0000_0000_0000_0000, 16'h8000);
        send(0, 16'h3FC1, 64'h8000_0000_0000_0001, 8'h09, 64'h0000_0000_0000_0001, 16'h0000);
        send(0, 16'h3FC0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0A, 64'h0000_0000_0000_0000, 16'h0000);
        send(0, 16'hBFFE, 64'hA000_0000_0000_0000, 8'h0B, 64'hA000_0000_0000_0000, 16'h7FFE);
        send(0, 16'hBFFF, 64'hA000_0000_0000_0000, 8'h0C, 64'h8000_0000_0000_0000, 16'h7FFF);
        send(0, 16'h4001, 64'h8000_0000_0000_0001, 8'h0D, 64'h8000_0000_0000_0001, 16'h0001);
        send(0, 16'h3FFF, 64'h8000_0000_0000_0003, 8'h0E, 64'h2000_0000_0000_0001, 16'h0000);
        send(1, 16'hFFFF, 64'hC000_0000_0000_0001, 8'h0F, 64'hC000_0000_0000_0001, 16'hFFFF);
        drain();

        // Backpressure: beat0 stalls, second operand parks in S1.
        out_ready = 1'b0;
        send(0, 16'h7FFF, 64'h8000_0000_0000_0000, 8'h10, 64'h8000_0000_0000_0000, 16'h3FFF);
        send(1, 16'h8000, 64'h8000_0000_0000_0000, 8'h11, 64'h8000_0000_0000_0000, 16'hC000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_data",  out_data,  64'h8000_0000_0000_0000);
            chk("stall_out_last",  out_last,  0);
            chk("stall_out_tag",   out_tag,   8'h10);
            chk("stall_in_ready",  in_ready,  0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Streaming: four operands, eight beats with no bubble.
        send(0, 16'h7FFF, 64'h8000_0000_0000_0000, 8'h20, 64'h8000_0000_0000_0000, 16'h3FFF);
        send(1, 16'h8000, 64'h8000_0000_0000_0000, 8'h21, 64'h8000_0000_0000_0000, 16'hC000);
        send(0, 16'hC000, 64'h8000_0000_0000_0000, 8'h22, 64'h8000_0000_0000_0000, 16'h7FFF);
        send(0, 16'h4000, 64'hC000_0000_0000_0001, 8'h23, 64'h6000_0000_0000_0000, 16'h0000);
        drain();
        chk("stream_beats", 64'(stream_cyc.size()), 64'd8);
        for (int i = 1; i < stream_cyc.size(); i++) begin
            chk("stream_gap", 64'(stream_cyc[i] - stream_cyc[i-1]), 64'd1);
        end

        // Reset while parked in BEAT1.
        out_ready = 1'b0;
        send(0, 16'h7FFF, 64'h8000_0000_0000_0000, 8'h30, 64'h8000_0000_0000_0000, 16'h3FFF);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_beat1", {out_valid, out_last}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready",  in_ready,  1);
        chk("mid_rst_out_last",  out_last,  0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send(1, 16'h8000, 64'h8000_0000_0000_0000, 8'h31, 64'h8000_0000_0000_0000, 16'hC000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
